write_back_stage: RTL
=====================

# write_back_stage

Parametrised MEM/WB pipeline register and write-back stage for the pipelined core. It captures the memory-stage results and selects one of four result sources. It aligns and extends sub-word load data, then drives the register-file write port one cycle later. It supports stall, flush and a retired-instruction counter. It replaces the single-cycle two-way write-back mux.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width; must be 32 when WB_LOAD_EXT_EN is defined
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 32, retire counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all pipeline state
- flush  in  1  replace the next captured entry with a bubble
- inValid  in  1  memory-stage entry is a real instruction
- RegWrite  in  1  entry writes the register file
- ResultSrc  in  2  00 ALUResult, 01 readData (load), 10 pcPlus4, 11 immExt
- LoadType  in  3  RISC-V funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- rdIn  in  REG_ADDR_WIDTH  destination register
- ALUResult  in  DATA_WIDTH  ALU result, also the load address
- readData  in  DATA_WIDTH  raw memory word
- pcPlus4  in  DATA_WIDTH  link value
- immExt  in  DATA_WIDTH  immediate, used for lui
- writeData  out  DATA_WIDTH  register-file write data
- rdOut  out  REG_ADDR_WIDTH  register-file write address
- regWriteOut  out  1  register-file write enable
- wbValid  out  1  stage holds a real instruction
- retired  out  CNT_WIDTH  count of instructions retired

## Operation
- Update priority each edge: rst > flush > stall > normal capture.
- rst: writeData, rdOut, regWriteOut, wbValid and retired all become 0.
- flush: the stage loads a bubble. wbValid=0, regWriteOut=0, rdOut=0, writeData=0. retired is unchanged. Flush wins over stall.
- stall without flush: all registers hold and retired does not increment.
- Normal capture: wbValid<=inValid and rdOut<=rdIn.
- regWriteOut<=RegWrite & inValid & (rdIn!=0). Register x0 is never written.
- writeData<=the source selected by ResultSrc. Select and extension are computed combinationally before the register.
- Load extension uses offset = ALUResult[1:0]:
  - byte lane = readData[8*offset +: 8]
  - half lane = readData[16*offset[1] +: 16]; offset[0] is ignored
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the full word
- Unlisted LoadType encodings behave as lw.
- retired increments by 1 on each normal capture with inValid=1. It wraps from 2^CNT_WIDTH-1 to 0 with no saturation or flag.

## Timing
- Latency is 1 cycle from the memory-stage inputs to the register-file outputs.
- All outputs are registered; there is no combinational input-to-output path.
- retired reflects captures up to and including the previous edge.
- Reset mid-stall or mid-flush: reset wins and all state clears on that edge.
- A stall released on cycle N means the inputs present at edge N are captured.

## Configuration
- WB_LOAD_EXT_EN defined: byte/half lane selection and extension is active as described in Operation.
- WB_LOAD_EXT_EN undefined: ResultSrc=01 passes readData unmodified regardless of LoadType. LoadType is ignored and any DATA_WIDTH is legal.

## Structure
- Shared package wb_pkg holds:
  - ResultSrc encodings: RES_ALU, RES_MEM, RES_PC4, RES_IMM
  - LoadType encodings: LD_B, LD_H, LD_W, LD_BU, LD_HU
- Sub-module load_extender: purely combinational, inputs readData, offset and LoadType, output the extended word. It is instantiated only under WB_LOAD_EXT_EN.
- The pipeline register and retire counter live in write_back_stage.

## Test plan
- Reset: assert rst for 2 cycles with inputs toggling. All outputs are 0 and retired=0.
- Source select: ALUResult=3, readData=2, pcPlus4=0x104, immExt=0x5000, rdIn=7, RegWrite=1, inValid=1. Drive ResultSrc=00/01/10/11 on four consecutive cycles. writeData is 3, 2, 0x104, 0x5000, each one cycle later. regWriteOut=1 and retired=4.
- Load extension (macro on): readData=0x80F1_7F82.
  - lb, offset 0: 0xFFFFFF82
  - lbu, offset 0: 0x00000082
  - lb, offset 1: 0x0000007F
  - lh, offset 2: 0xFFFF80F1
  - lhu, offset 2: 0x000080F1
  - lw: 0x80F17F82
- x0 and invalid entries:
  - rdIn=0, RegWrite=1: regWriteOut=0, wbValid=1
  - inValid=0: regWriteOut=0, wbValid=0, retired unchanged
- Stall and flush:
  - Capture an entry, then stall for 3 cycles while the inputs change: outputs hold and retired is constant.
  - flush together with stall: the bubble is loaded on that edge.
- Counter wrap: CNT_WIDTH=4, 17 valid captures. retired goes 15, then 0, then 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB write-back stage: result-source select and
// RISC-V load funct3 codes.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } load_type_e;

endpackage

// File: rtl/load_extender.sv
// Combinational sub-word load alignment and sign/zero extension for a 32-bit
// memory word; unlisted funct3 codes fall through as a full-word load.
module load_extender
  import wb_pkg::*;
(
  input  logic [31:0] readData,
  input  logic [1:0]  offset,
  input  logic [2:0]  LoadType,
  output logic [31:0] extData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword lane only looks at offset[1]; misaligned halves are not split.
  assign w_byte = readData[8*offset +: 8];
  assign w_half = offset[1] ? readData[31:16] : readData[15:0];

  always_comb begin
    extData = readData;
    case (LoadType)
      LD_B:    extData = {{24{w_byte[7]}}, w_byte};
      LD_H:    extData = {{16{w_half[15]}}, w_half};
      LD_BU:   extData = {24'b0, w_byte};
      LD_HU:   extData = {16'b0, w_half};
      default: extData = readData;
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// MEM/WB pipeline register with 4-way result select and retire counter.
// Define WB_LOAD_EXT_EN to enable sub-word load extension (DATA_WIDTH must be 32).
module write_back_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      inValid,
  input  logic                      RegWrite,
  input  logic [1:0]                ResultSrc,
  input  logic [2:0]                LoadType,
  input  logic [REG_ADDR_WIDTH-1:0] rdIn,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic [DATA_WIDTH-1:0]     readData,
  input  logic [DATA_WIDTH-1:0]     pcPlus4,
  input  logic [DATA_WIDTH-1:0]     immExt,
  output logic [DATA_WIDTH-1:0]     writeData,
  output logic [REG_ADDR_WIDTH-1:0] rdOut,
  output logic                      regWriteOut,
  output logic                      wbValid,
  output logic [CNT_WIDTH-1:0]      retired
);

  logic [DATA_WIDTH-1:0]     w_mem;
  logic [DATA_WIDTH-1:0]     w_result;
  logic                      w_we;

  logic [DATA_WIDTH-1:0]     r_wd;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_we;
  logic                      r_vld;
  logic [CNT_WIDTH-1:0]      r_retired;

`ifdef WB_LOAD_EXT_EN
  load_extender u_ext (
    .readData (readData),
    .offset   (ALUResult[1:0]),
    .LoadType (LoadType),
    .extData  (w_mem)
  );
`else
  logic w_unused_lt;
  assign w_unused_lt = ^LoadType;
  assign w_mem       = readData;
`endif

  always_comb begin
    w_result = ALUResult;
    case (ResultSrc)
      RES_ALU: w_result = ALUResult;
      RES_MEM: w_result = w_mem;
      RES_PC4: w_result = pcPlus4;
      RES_IMM: w_result = immExt;
      default: w_result = ALUResult;
    endcase
  end

  // x0 is hard-wired zero, so never raise the write enable for it.
  assign w_we = RegWrite & inValid & (rdIn != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd      <= '0;
      r_rd      <= '0;
      r_we      <= 1'b0;
      r_vld     <= 1'b0;
      r_retired <= '0;
    end else if (flush) begin
      r_wd  <= '0;
      r_rd  <= '0;
      r_we  <= 1'b0;
      r_vld <= 1'b0;
    end else if (!stall) begin
      r_wd  <= w_result;
      r_rd  <= rdIn;
      r_we  <= w_we;
      r_vld <= inValid;
      if (inValid) r_retired <= r_retired + CNT_WIDTH'(1);
    end
  end

  assign writeData   = r_wd;
  assign rdOut       = r_rd;
  assign regWriteOut = r_we;
  assign wbValid     = r_vld;
  assign retired     = r_retired;

endmodule
